// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: bus-mapped RX/TX FIFOs with FSMs sequencing the UART receive handshake and transmit pulses.
module uart_mmio_bridge #(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  addr,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  input  logic        rx_flag,
  input  logic [7:0]  rx_data,
  input  logic        parity_error,
  input  logic        uart_busy,
  output logic        rx_flag_clr,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  output logic        irq
);
  localparam int RA = $clog2(RX_DEPTH);
  localparam int TA = $clog2(TX_DEPTH);
  localparam logic [RA:0] RX_FULL = (RA+1)'(RX_DEPTH);
  localparam logic [TA:0] TX_FULL = (TA+1)'(TX_DEPTH);
  localparam logic [RA:0] RX_ONE = (RA+1)'(1);
  localparam logic [TA:0] TX_ONE = (TA+1)'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_WAIT_DONE, RX_CAPTURE, RX_CLEAR} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;
  logic [7:0] rx_mem [RX_DEPTH];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [RA-1:0] rx_wp, rx_rp;
  logic [TA-1:0] tx_wp, tx_rp;
  logic [RA:0] rx_cnt, rx_cnt_nx;
  logic [TA:0] tx_cnt, tx_cnt_nx;
  logic [1:0] tmo;
  logic rx_overrun, par_err, ovr_nx, par_nx;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_push, rx_pop, tx_push, tx_pop, capture, st_wr;

  assign rx_full  = rx_cnt == RX_FULL;
  assign rx_empty = rx_cnt == '0;
  assign tx_full  = tx_cnt == TX_FULL;
  assign tx_empty = tx_cnt == '0;
  assign capture  = rx_state == RX_CAPTURE;
  assign rx_pop   = sel & re & (addr == 2'd0) & ~rx_empty;
  // A same-cycle CPU pop frees a slot, so a capture into a full FIFO still lands.
  assign rx_push  = capture & (~rx_full | rx_pop);
  assign tx_pop   = tx_state == TX_START;
  assign tx_push  = sel & we & (addr == 2'd0) & (~tx_full | tx_pop);
  assign st_wr    = sel & we & (addr == 2'd1);
  assign ovr_nx   = (capture & rx_full & ~rx_pop) | (rx_overrun & ~(st_wr & wdata[2]));
  assign par_nx   = (capture & parity_error) | (par_err & ~(st_wr & wdata[3]));
  assign rx_cnt_nx = (rx_push & ~rx_pop) ? rx_cnt + RX_ONE : (rx_pop & ~rx_push) ? rx_cnt - RX_ONE : rx_cnt;
  assign tx_cnt_nx = (tx_push & ~tx_pop) ? tx_cnt + TX_ONE : (tx_pop & ~tx_push) ? tx_cnt - TX_ONE : tx_cnt;
  assign rx_flag_clr = rx_state == RX_CLEAR;
  assign tx_send     = tx_state == TX_START;

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:      rx_next = rx_flag ? RX_WAIT_DONE : RX_IDLE;
      RX_WAIT_DONE: rx_next = uart_busy ? RX_WAIT_DONE : RX_CAPTURE;
      RX_CAPTURE:   rx_next = RX_CLEAR;
      default:      rx_next = RX_IDLE;
    endcase
  end

  // The busy timeout covers a UART whose busy flag rises late or never.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:      tx_next = (~tx_empty & ~uart_busy) ? TX_START : TX_IDLE;
      TX_START:     tx_next = TX_WAIT_BUSY;
      TX_WAIT_BUSY: tx_next = (uart_busy | (tmo == 2'd3)) ? TX_WAIT_DONE : TX_WAIT_BUSY;
      default:      tx_next = uart_busy ? TX_WAIT_DONE : TX_IDLE;
    endcase
  end

  always_comb begin
    rdata = addr == 2'd0 ? {24'b0, rx_empty ? 8'h00 : rx_mem[rx_rp]}
          : addr == 2'd1 ? {26'b0, uart_busy, tx_empty, par_err, rx_overrun, tx_full, ~rx_empty}
          : addr == 2'd2 ? 32'(rx_cnt)
          : 32'b0;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_data;
    if (tx_push) tx_mem[tx_wp] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      tx_state   <= TX_IDLE;
      rx_wp      <= '0;
      rx_rp      <= '0;
      tx_wp      <= '0;
      tx_rp      <= '0;
      rx_cnt     <= '0;
      tx_cnt     <= '0;
      rx_overrun <= 1'b0;
      par_err    <= 1'b0;
      irq        <= 1'b0;
      tmo        <= 2'd0;
      tx_data    <= 8'h00;
    end else begin
      rx_state   <= rx_next;
      tx_state   <= tx_next;
      rx_cnt     <= rx_cnt_nx;
      tx_cnt     <= tx_cnt_nx;
      rx_overrun <= ovr_nx;
      par_err    <= par_nx;
      irq        <= (rx_cnt_nx != '0) | ovr_nx;
      tmo        <= tx_state == TX_WAIT_BUSY ? tmo + 2'd1 : 2'd0;
      if (rx_push) rx_wp <= rx_wp + RA'(1);
      if (rx_pop) rx_rp <= rx_rp + RA'(1);
      if (tx_push) tx_wp <= tx_wp + TA'(1);
      if (tx_pop) tx_rp <= tx_rp + TA'(1);
      if (tx_state == TX_IDLE && tx_next == TX_START) tx_data <= tx_mem[tx_rp];
    end
  end
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb_uart_mmio_bridge: scoreboard bench with a behavioural UART driving rx_flag/busy and logging tx_send pulses.
module tb_uart_mmio_bridge;
  logic clk = 1'b0, rst = 1'b1, sel = 1'b0, we = 1'b0, re = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00, rx_data = 8'h00;
  logic [31:0] rdata;
  logic rx_flag = 1'b0, parity_error = 1'b0, uart_busy;
  logic rx_flag_clr, tx_send, irq;
  logic [7:0] tx_data;
  logic rx_busy = 1'b0, hold_busy = 1'b0, tx_model = 1'b1, busy_edge = 1'b0;
  int tx_busy_cnt = 0, bad_send = 0, checks = 0, failures = 0;
  logic [7:0] rx_exp[$], tx_exp[$], tx_log[$];

  assign uart_busy = rx_busy | hold_busy | (tx_busy_cnt != 0);

  uart_mmio_bridge #(.RX_DEPTH(8), .TX_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rx_flag(rx_flag), .rx_data(rx_data), .parity_error(parity_error),
    .uart_busy(uart_busy), .rx_flag_clr(rx_flag_clr), .tx_data(tx_data),
    .tx_send(tx_send), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) busy_edge = uart_busy;

  always @(negedge clk) begin
    if (tx_send) begin
      tx_log.push_back(tx_data);
      if (busy_edge) bad_send++;
    end
    if (tx_busy_cnt != 0) tx_busy_cnt--;
    if (tx_send && tx_model) tx_busy_cnt = 10;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; re = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk);
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic deliver(input logic [7:0] b, input logic par, output int lat);
    rx_data = b; parity_error = par; rx_flag = 1'b1; rx_busy = 1'b1;
    @(negedge clk);
    rx_busy = 1'b0; lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (rx_flag_clr) lat = i;
    end
    rx_flag = 1'b0; parity_error = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    @(negedge clk); @(negedge clk);
    checks++; if ({rx_flag_clr, tx_send, irq, tx_data} !== 11'd0) begin failures++; $display("FAIL reset_outputs got=%0h exp=0", {rx_flag_clr, tx_send, irq, tx_data}); end
    rst = 1'b0;
    @(negedge clk);
    bus_read(2'd1, d);
    checks++; if (d !== 32'h10) begin failures++; $display("FAIL reset_status got=%0h exp=10", d); end
    bus_read(2'd2, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_rxcnt got=%0h exp=0", d); end
    bus_read(2'd3, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reg3_read got=%0h exp=0", d); end
  endtask

  task automatic test_rx;
    logic [31:0] d;
    int lat;
    rx_exp.push_back(8'hA5);
    deliver(8'hA5, 1'b0, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rx_clr_latency got=%0d exp=2", lat); end
    @(negedge clk);
    checks++; if (rx_flag_clr !== 1'b0) begin failures++; $display("FAIL rx_clr_width got=%b exp=0", rx_flag_clr); end
    bus_read(2'd2, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL rx_rxcnt got=%0h exp=1", d); end
    bus_read(2'd1, d);
    checks++; if (d[0] !== 1'b1) begin failures++; $display("FAIL rx_nempty got=%b exp=1", d[0]); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rx_irq got=%b exp=1", irq); end
    bus_read(2'd0, d);
    checks++; if (d !== {24'b0, rx_exp.pop_front()}) begin failures++; $display("FAIL rx_data got=%0h exp=a5", d); end
    bus_read(2'd2, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rx_rxcnt_after got=%0h exp=0", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rx_irq_after got=%b exp=0", irq); end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    logic [7:0] e;
    int lat;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) rx_exp.push_back(8'(i));
      deliver(8'(i), 1'b0, lat);
      checks++; if (lat == 0) begin failures++; $display("FAIL ovf_clr_timeout got=%0d exp=nonzero", lat); end
    end
    @(negedge clk);
    bus_read(2'd2, d);
    checks++; if (d !== 32'h8) begin failures++; $display("FAIL ovf_rxcnt got=%0h exp=8", d); end
    bus_read(2'd1, d);
    checks++; if (d[2] !== 1'b1) begin failures++; $display("FAIL ovf_overrun got=%b exp=1", d[2]); end
    while (rx_exp.size() > 0) begin
      e = rx_exp.pop_front();
      bus_read(2'd0, d);
      checks++; if (d !== {24'b0, e}) begin failures++; $display("FAIL ovf_data got=%0h exp=%0h", d, e); end
    end
    bus_read(2'd0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL empty_read got=%0h exp=0", d); end
    bus_read(2'd2, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL empty_no_pop got=%0h exp=0", d); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ovf_irq got=%b exp=1", irq); end
    bus_write(2'd1, 8'h04);
    bus_read(2'd1, d);
    checks++; if (d[2] !== 1'b0) begin failures++; $display("FAIL ovf_w1c got=%b exp=0", d[2]); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ovf_irq_clr got=%b exp=0", irq); end
  endtask

  task automatic test_parity;
    logic [31:0] d;
    int lat;
    rx_exp.push_back(8'h5A);
    deliver(8'h5A, 1'b1, lat);
    @(negedge clk);
    bus_read(2'd1, d);
    checks++; if (d[3] !== 1'b1) begin failures++; $display("FAIL par_set got=%b exp=1", d[3]); end
    bus_write(2'd1, 8'h04);
    bus_read(2'd1, d);
    checks++; if (d[3] !== 1'b1) begin failures++; $display("FAIL par_wrong_clr got=%b exp=1", d[3]); end
    bus_write(2'd1, 8'h08);
    bus_read(2'd1, d);
    checks++; if (d[3] !== 1'b0) begin failures++; $display("FAIL par_w1c got=%b exp=0", d[3]); end
    bus_read(2'd0, d);
    checks++; if (d !== {24'b0, rx_exp.pop_front()}) begin failures++; $display("FAIL par_data got=%0h exp=5a", d); end
  endtask

  task automatic test_tx;
    logic [31:0] d;
    logic [7:0] e, g;
    tx_log.delete(); bad_send = 0;
    foreach (tx_exp[i]) tx_exp.delete(i);
    for (int i = 0; i < 3; i++) begin
      tx_exp.push_back(8'h55 + 8'(i * 17));
      bus_write(2'd0, 8'h55 + 8'(i * 17));
    end
    for (int i = 0; i < 300 && tx_log.size() < 3; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++; if (tx_log.size() !== 3) begin failures++; $display("FAIL tx_count got=%0d exp=3", tx_log.size()); end
    while (tx_exp.size() > 0 && tx_log.size() > 0) begin
      e = tx_exp.pop_front(); g = tx_log.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL tx_order got=%0h exp=%0h", g, e); end
    end
    checks++; if (bad_send !== 0) begin failures++; $display("FAIL tx_send_while_busy got=%0d exp=0", bad_send); end
    bus_read(2'd1, d);
    checks++; if (d[4] !== 1'b1) begin failures++; $display("FAIL tx_empty got=%b exp=1", d[4]); end
  endtask

  task automatic test_tx_full;
    logic [31:0] d;
    logic [7:0] e, g;
    tx_log.delete(); tx_exp.delete(); bad_send = 0;
    hold_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_exp.push_back(8'h10 + 8'(i));
      bus_write(2'd0, 8'h10 + 8'(i));
    end
    bus_read(2'd1, d);
    checks++; if (d[1] !== 1'b1) begin failures++; $display("FAIL tx_full got=%b exp=1", d[1]); end
    checks++; if (tx_log.size() !== 0) begin failures++; $display("FAIL tx_held got=%0d exp=0", tx_log.size()); end
    hold_busy = 1'b0;
    for (int i = 0; i < 400 && tx_log.size() < 8; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    checks++; if (tx_log.size() !== 8) begin failures++; $display("FAIL txf_count got=%0d exp=8", tx_log.size()); end
    while (tx_exp.size() > 0 && tx_log.size() > 0) begin
      e = tx_exp.pop_front(); g = tx_log.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL txf_order got=%0h exp=%0h", g, e); end
    end
    checks++; if (bad_send !== 0) begin failures++; $display("FAIL txf_send_while_busy got=%0d exp=0", bad_send); end
  endtask

  task automatic test_push_pop_full;
    logic [31:0] d;
    logic [7:0] e;
    int lat;
    for (int i = 0; i < 8; i++) begin
      rx_exp.push_back(8'h21 + 8'(i));
      deliver(8'h21 + 8'(i), 1'b0, lat);
    end
    @(negedge clk);
    rx_data = 8'h99; rx_flag = 1'b1; rx_busy = 1'b1;
    @(negedge clk);
    rx_busy = 1'b0;
    @(negedge clk);
    sel = 1'b1; re = 1'b1; addr = 2'd0;
    #1 d = rdata;
    e = rx_exp.pop_front();
    rx_exp.push_back(8'h99);
    checks++; if (d !== {24'b0, e}) begin failures++; $display("FAIL pp_read got=%0h exp=%0h", d, e); end
    @(negedge clk);
    sel = 1'b0; re = 1'b0;
    checks++; if (rx_flag_clr !== 1'b1) begin failures++; $display("FAIL pp_clr got=%b exp=1", rx_flag_clr); end
    rx_flag = 1'b0;
    @(negedge clk);
    bus_read(2'd1, d);
    checks++; if (d[2] !== 1'b0) begin failures++; $display("FAIL pp_overrun got=%b exp=0", d[2]); end
    bus_read(2'd2, d);
    checks++; if (d !== 32'h8) begin failures++; $display("FAIL pp_rxcnt got=%0h exp=8", d); end
    while (rx_exp.size() > 0) begin
      e = rx_exp.pop_front();
      bus_read(2'd0, d);
      checks++; if (d !== {24'b0, e}) begin failures++; $display("FAIL pp_drain got=%0h exp=%0h", d, e); end
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    int lat;
    deliver(8'h11, 1'b0, lat);
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mf_irq_pre got=%b exp=1", irq); end
    rx_data = 8'h3C; rx_flag = 1'b1; rx_busy = 1'b1;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1; addr = 2'd2;
    #1;
    checks++; if ({rx_flag_clr, tx_send, irq, tx_data} !== 11'd0) begin failures++; $display("FAIL mf_async_clear got=%0h exp=0", {rx_flag_clr, tx_send, irq, tx_data}); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL mf_rxcnt_clear got=%0h exp=0", rdata); end
    rx_exp.delete();
    @(negedge clk);
    rst = 1'b0; rx_busy = 1'b0;
    rx_exp.push_back(8'h3C);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (rx_flag_clr) lat = i;
    end
    rx_flag = 1'b0;
    checks++; if (lat == 0) begin failures++; $display("FAIL mf_recapture got=timeout exp=clr_pulse"); end
    @(negedge clk);
    bus_read(2'd2, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL mf_rxcnt got=%0h exp=1", d); end
    bus_read(2'd0, d);
    checks++; if (d !== {24'b0, rx_exp.pop_front()}) begin failures++; $display("FAIL mf_data got=%0h exp=3c", d); end
  endtask

  initial begin
    test_reset;
    test_rx;
    test_overflow;
    test_parity;
    test_tx;
    test_tx_full;
    test_push_pop_full;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
- Memory-mapped front end between the single-cycle core's peripheral bus and the full-duplex UART block.
- Downstream of the receiver: it consumes received bytes via `rx_flag` and `rx_data`, buffers them in an RX FIFO, and acknowledges with `rx_flag_clr`.
- Upstream of the transmitter: it buffers CPU writes in a TX FIFO and issues `tx_send` and `tx_data` one byte at a time.

Parameters:
- RX_DEPTH, 8, RX FIFO entries; power of two, minimum 2.
- TX_DEPTH, 8, TX FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sel  in  1  bus select for this peripheral
- we  in  1  write strobe, qualified by sel
- re  in  1  read strobe, qualified by sel
- addr  in  2  word address, bus addr[3:2]
- wdata  in  8  write data
- rdata  out  32  read data, combinational
- rx_flag  in  1  UART receive flag
- rx_data  in  8  UART received byte
- parity_error  in  1  UART parity error for the current byte
- uart_busy  in  1  UART busy (RX or TX active)
- rx_flag_clr  out  1  one-cycle clear pulse to the UART
- tx_data  out  8  byte presented to the UART transmitter
- tx_send  out  1  one-cycle start pulse to the transmitter
- irq  out  1  level interrupt: RX FIFO not empty or overrun

Behaviour:
- Reset (async, rst=1) clears the following to 0:
  - both FIFO pointers and counts;
  - all sticky flags;
  - `rx_flag_clr`, `tx_send`, `tx_data`, `irq`;
  - both FSMs return to IDLE.
- Register map (addr):
  - 0 DATA: write pushes `wdata[7:0]` into the TX FIFO. Read returns `{24'b0, RX head}` and pops on the clock edge where sel&re. Reading an empty FIFO returns 0 and does not pop.
  - 1 STATUS, read: bit0 rx_nempty, bit1 tx_full, bit2 rx_overrun, bit3 par_err, bit4 tx_empty, bit5 uart_busy.
  - 1 STATUS, write: bits 2 and 3 are write-1-to-clear; all other bits are ignored.
  - 2 RXCNT: read-only RX occupancy, zero-extended.
  - 3: reads 0, writes ignored.
- Writing DATA while the TX FIFO is full drops the byte silently. tx_full stays 1.
- RX FSM (states IDLE, WAIT_DONE, CAPTURE, CLEAR):
  - IDLE -> WAIT_DONE when rx_flag=1.
  - WAIT_DONE -> CAPTURE when uart_busy=0. This marks the end of the frame; the data register is now valid.
  - CAPTURE, one cycle:
    - if not full, push `rx_data`;
    - if full, set rx_overrun and discard the byte, keeping the old contents;
    - if `parity_error`=1, set par_err.
  - CLEAR: `rx_flag_clr`=1 for exactly one cycle, then -> IDLE.
  - rx_flag is ignored outside IDLE.
  - Capture is deferred while TX is active; this is accepted behaviour.
- TX FSM (states IDLE, START, WAIT_BUSY, WAIT_DONE):
  - IDLE -> START when the TX FIFO is not empty and uart_busy=0.
  - START, one cycle: `tx_data`=head, `tx_send`=1, pop.
  - `tx_data` holds its value until the next START.
  - START -> WAIT_BUSY.
  - WAIT_BUSY -> WAIT_DONE when uart_busy=1, or after 4 cycles as a timeout, to tolerate a busy signal that lags.
  - WAIT_DONE -> IDLE when uart_busy=0.
- FIFO rules:
  - pointers are log2(DEPTH) bits and wrap modulo DEPTH;
  - count is log2(DEPTH)+1 bits;
  - full when count==DEPTH, empty when count==0.
- Simultaneous events in the same cycle:
  - RX push with CPU pop: both occur, count unchanged. This is legal even when full, since the pop frees the slot, so no overrun.
  - TX push from CPU with FSM pop: both occur.
  - CAPTURE with STATUS write-1-to-clear of overrun: the set wins.
- `irq` is registered: `irq` = rx_nempty | rx_overrun, evaluated after each edge.
- Reset asserted mid-frame:
  - everything clears immediately;
  - a pending rx_flag is captured again after reset if still high.
- Reset asserted mid-TX:
  - `tx_send` is never reissued for a byte already popped;
  - the UART may finish that frame.

Test Plan:
- Receive path: pulse rx_flag with rx_data=8'hA5, then drop uart_busy. Required:
  - `rx_flag_clr` pulses for 1 cycle two cycles later;
  - RXCNT=1, STATUS bit0=1, `irq`=1;
  - DATA read returns 32'h000000A5, then RXCNT=0 and `irq`=0.
- Overflow: RX_DEPTH=8, deliver 9 bytes 0x01..0x09 with no reads. Required:
  - RXCNT=8, rx_overrun=1;
  - reads return 0x01..0x08 in order;
  - writing STATUS=0x04 clears overrun.
- Transmit path: write 0x55, 0x66, 0x77 to DATA with uart_busy low. Required:
  - `tx_send` pulses with `tx_data`=0x55;
  - model busy for 10 cycles, and the next pulse comes only after busy falls;
  - bytes go out in order; tx_empty=1 at the end.
- TX full: write 9 bytes with uart_busy held high. Required: tx_full=1, the 9th byte is dropped, and exactly 8 `tx_send` pulses occur after busy releases.
- Simultaneous push/pop with the RX FIFO full: CAPTURE coincides with a DATA read. Required: no overrun and RXCNT stays 8.
- Reset mid-frame: rx_flag high in WAIT_DONE, assert rst. Required:
  - all outputs 0 asynchronously;
  - after release, the byte is captured once busy is low.
- Parity: a capture with parity_error=1. Required: STATUS bit3=1, and it clears on a 0x08 write.
